// File: rtl/lz77_pkg.sv
// Shared LZ77 constants, field widths and decoder state encoding.
// Used by both the encoder and decoder sides of the codec.
package lz77_pkg;

  localparam int SEARCH_LEN = 9;
  localparam int LOOK_LEN   = 8;
  localparam int WCHAR      = 8;
  localparam int OFF_W      = 4;
  localparam int LEN_W      = 3;

  localparam logic [WCHAR-1:0] END_SGN = 8'h24;

  typedef enum logic [1:0] {
    IDLE,
    COPY,
    LIT,
    DONE
  } dec_state_t;

endpackage

// File: rtl/lz77_hist_buf.sv
// History shift register: newest char at index 0, clamped indexed read, resets to INIT.
// Read is combinational from registers; a same-cycle push and read returns the pre-push value.
module lz77_hist_buf
  import lz77_pkg::*;
#(
  parameter int               DEPTH = 9,
  parameter int               W     = 8,
  parameter logic [W-1:0]     INIT  = 8'h24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [W-1:0]     push_dat,
  input  logic [OFF_W-1:0] rd_idx,
  output logic [W-1:0]     rd_dat
);

  localparam logic [OFF_W-1:0] MAX_IDX = OFF_W'(DEPTH - 1);

  logic [W-1:0]     hist [DEPTH];
  logic [OFF_W-1:0] idx_c;

  // Out-of-range offsets read the oldest entry rather than garbage.
  always_comb begin
    idx_c  = (rd_idx > MAX_IDX) ? MAX_IDX : rd_idx;
    rd_dat = hist[idx_c];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) hist[k] <= INIT;
    end else if (push) begin
      hist[0] <= push_dat;
      for (int k = 1; k < DEPTH; k++) hist[k] <= hist[k-1];
    end
  end

endmodule

// File: rtl/lz77_decoder.sv
// Streaming LZ77 decoder: (offset, match_len, char_nxt) in, one char per cycle out, first char the cycle after accept.
// Backpressure: code_ready only in IDLE or a non-terminal LIT cycle, so back-to-back codewords stream with no bubbles.
module lz77_decoder
  import lz77_pkg::*;
#(
  parameter int                 SEARCH_LEN = 9,
  parameter int                 WCHAR      = 8,
  parameter logic [WCHAR-1:0]   END_SGN    = 8'h24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             code_valid,
  output logic             code_ready,
  input  logic [OFF_W-1:0] offset,
  input  logic [LEN_W-1:0] match_len,
  input  logic [WCHAR-1:0] char_nxt,
  output logic             out_valid,
  output logic [WCHAR-1:0] char_out,
  output logic             finish,
  output logic             encode
);

  dec_state_t       state;
  logic [OFF_W-1:0] off_q;
  logic [LEN_W-1:0] rem_q;
  logic [WCHAR-1:0] lit_q;
  logic [WCHAR-1:0] hist_rd;
  logic             accept;

  // Ready is a decode of registered state only; reset forces it low.
  assign code_ready = reset & ((state == IDLE) | ((state == LIT) & (lit_q != END_SGN)));
  assign accept     = code_valid & code_ready;
  assign out_valid  = (state == COPY) | (state == LIT);
  assign finish     = (state == DONE);
  assign encode     = 1'b0;

  always_comb begin
    char_out = '0;
    if (state == COPY)     char_out = hist_rd;
    else if (state == LIT) char_out = lit_q;
  end

  lz77_hist_buf #(
    .DEPTH (SEARCH_LEN),
    .W     (WCHAR),
    .INIT  (END_SGN)
  ) u_hist (
    .clk      (clk),
    .reset    (reset),
    .push     (out_valid),
    .push_dat (char_out),
    .rd_idx   (off_q),
    .rd_dat   (hist_rd)
  );

  // off_q stays fixed through COPY: the push moves the match along under it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      off_q <= '0;
      rem_q <= '0;
      lit_q <= '0;
    end else begin
      case (state)
        IDLE, LIT: begin
          if (state == LIT && lit_q == END_SGN) begin
            state <= DONE;
          end else if (accept) begin
            off_q <= offset;
            rem_q <= match_len;
            lit_q <= char_nxt;
            state <= (match_len != '0) ? COPY : LIT;
          end else begin
            state <= IDLE;
          end
        end
        COPY: begin
          rem_q <= rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state <= LIT;
        end
        DONE:    state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lz77_decoder.sv
// Scoreboard bench for lz77_decoder: a reference history model predicts the char stream.
// Expected chars are queued when a codeword is driven and popped as the decoder emits them.
module tb_lz77_decoder;

  localparam logic [7:0] DOLLAR = 8'h24;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       code_valid = 1'b0;
  logic       code_ready;
  logic [3:0] offset = '0;
  logic [2:0] match_len = '0;
  logic [7:0] char_nxt = '0;
  logic       out_valid;
  logic [7:0] char_out;
  logic       finish;
  logic       encode;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          out_cnt = 0;
  int          last_cyc = 0;
  logic [31:0] rdy_hist = '0;
  logic [7:0]  exp_q [$];
  logic [7:0]  mh [9];

  lz77_decoder u_dut (
    .clk        (clk),
    .reset      (reset),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .offset     (offset),
    .match_len  (match_len),
    .char_nxt   (char_nxt),
    .out_valid  (out_valid),
    .char_out   (char_out),
    .finish     (finish),
    .encode     (encode)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_out", {31'd0, out_valid}, 32'd0);
      else                   chk("char", {24'd0, char_out}, {24'd0, exp_q.pop_front()});
      rdy_hist = {rdy_hist[30:0], code_ready};
      out_cnt++;
      last_cyc = cyc;
    end
  end

  task automatic model_push(input logic [7:0] c);
    for (int k = 8; k > 0; k--) mh[k] = mh[k-1];
    mh[0] = c;
    exp_q.push_back(c);
  endtask

  task automatic send(input logic [3:0] o, input logic [2:0] l, input logic [7:0] c);
    int n = 0;
    offset = o; match_len = l; char_nxt = c; code_valid = 1'b1;
    for (int i = 0; i < int'(l); i++) model_push(mh[(o > 4'd8) ? 4'd8 : o]);
    model_push(c);
    while (!code_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!code_ready) chk("accept_timeout", {31'd0, code_ready}, 32'd1);
    else begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_hist_init();
    for (int k = 0; k < 9; k++) chk($sformatf("hist_init[%0d]", k), {24'd0, u_dut.u_hist.hist[k]}, {24'd0, DOLLAR});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    code_valid = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 9; k++) mh[k] = DOLLAR;
    repeat (3) begin
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_char_out", {24'd0, char_out}, 32'd0);
      chk("rst_finish", {31'd0, finish}, 32'd0);
      chk("rst_code_ready", {31'd0, code_ready}, 32'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, code_ready}, 32'd1);
    check_hist_init();
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int base;
    int first_c;

    do_reset();
    chk("encode", {31'd0, encode}, 32'd0);

    // Literal-only codeword, latency and return to IDLE.
    send(4'd0, 3'd0, 8'h61);
    chk("lit_lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lit_lat_char", {24'd0, char_out}, 32'h61);
    code_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("lit_after_valid", {31'd0, out_valid}, 32'd0);
    chk("lit_after_ready", {31'd0, code_ready}, 32'd1);

    // Overlapping copy: a then a,a,a,b.
    send(4'd0, 3'd3, 8'h62);
    code_valid = 1'b0;
    drain();

    // Abort with reset during the second char of (0,5,'q').
    do_reset();
    send(4'd0, 3'd5, 8'h71);
    code_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_2nd_valid", {31'd0, out_valid}, 32'd1);
    chk("abort_2nd_char", {24'd0, char_out}, {24'd0, DOLLAR});
    reset = 1'b0;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_char", {24'd0, char_out}, 32'd0);
    chk("abort_ready", {31'd0, code_ready}, 32'd0);
    do_reset();

    // Initial history read: $,$,c.
    send(4'd8, 3'd2, 8'h63);
    code_valid = 1'b0;
    drain();

    // Back-to-back stream x,x,y,x,y,z with no gaps.
    do_reset();
    base = out_cnt;
    send(4'd0, 3'd0, 8'h78);
    first_c = cyc;
    send(4'd0, 3'd1, 8'h79);
    send(4'd1, 3'd2, 8'h7a);
    code_valid = 1'b0;
    drain();
    chk("b2b_count", out_cnt - base, 6);
    chk("b2b_span", last_cyc - first_c, 5);
    chk("b2b_ready_pattern", {26'd0, rdy_hist[5:0]}, 32'b101001);

    // Termination: '$' then sticky finish, further codewords ignored.
    send(4'd0, 3'd0, DOLLAR);
    code_valid = 1'b0;
    drain();
    chk("done_finish", {31'd0, finish}, 32'd1);
    chk("done_ready", {31'd0, code_ready}, 32'd0);
    chk("done_valid", {31'd0, out_valid}, 32'd0);
    base = out_cnt;
    offset = 4'd0; match_len = 3'd2; char_nxt = 8'h77; code_valid = 1'b1;
    repeat (8) @(negedge clk);
    code_valid = 1'b0;
    chk("done_no_out", out_cnt - base, 0);
    chk("done_finish_sticky", {31'd0, finish}, 32'd1);
    chk("done_ready_sticky", {31'd0, code_ready}, 32'd0);
    chk("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/lz77_decoder.md
# lz77_decoder

Streaming LZ77 decoder. It is the receive-side counterpart of the team's LZ77 encoder: 9-char search buffer, 8-char look-ahead, 4-bit offset, 3-bit match length, `$` (8'h24) end symbol. It accepts one (offset, match_len, char_nxt) codeword per handshake and emits the reconstructed byte stream one char per cycle. It asserts finish after the terminating `$` has been emitted.

## Interface
Parameters:
- SEARCH_LEN, 9: history depth in chars; legal offsets are 0..SEARCH_LEN-1.
- WCHAR, 8: char width.
- END_SGN, 8'h24: terminating literal; also the history initialisation value.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low; clears all state immediately.
- code_valid  input  1  codeword present on offset/match_len/char_nxt.
- code_ready  output  1  decoder can accept a codeword this cycle.
- offset  input  4  match start; 0 = most recently emitted char.
- match_len  input  3  chars copied from history, 0..7.
- char_nxt  input  8  literal emitted after the copied chars.
- out_valid  output  1  char_out is a decoded char this cycle.
- char_out  output  8  decoded char; 0 when out_valid=0.
- finish  output  1  sticky; high once END_SGN literal has been emitted.
- encode  output  1  tied 0 (decoder mode flag, mirrors encoder's tied-1).

## Operation
- The history buffer hist[0..8] is a shift register. hist[0] is the newest char. On reset all entries = END_SGN.
- States:
  - IDLE: code_ready=1, out_valid=0.
  - COPY: emits char_out = hist[off_q], out_valid=1.
  - LIT: emits char_out = lit_q, out_valid=1.
  - DONE: code_ready=0, out_valid=0, finish=1.
- Accept = code_valid & code_ready. On accept: off_q<=offset, rem_q<=match_len, lit_q<=char_nxt. Next state is COPY if match_len>0, otherwise LIT.
- COPY: each cycle push char_out into hist[0] (hist[k+1]<=hist[k], hist[8] dropped) and rem_q<=rem_q-1. When rem_q==1, next state is LIT.
- off_q is not adjusted during COPY. Because of the push, the same index walks forward through the match, so overlapping matches (offset < match_len-1) reproduce run-length correctly.
- LIT: push lit_q into hist.
  - If lit_q==END_SGN: next state is DONE.
  - Otherwise code_ready=1 in the same cycle. On accept, next state is COPY/LIT per the new codeword; without accept, next state is IDLE.
- offset ignored when match_len=0. Offsets 9..15 are illegal; the implementation clamps the read index to 8. Benches do not drive them.
- DONE is left only by reset. Codewords presented in DONE are ignored.

## Timing
- code_ready and out_valid/char_out are combinational from registered state only. There is no combinational path from code_valid or the codeword inputs to any output.
- Latency: a codeword accepted at edge N produces its first char in the cycle after edge N.
- A codeword occupies exactly match_len+1 output cycles.
- Back-to-back accepts (code_ready in LIT) give zero bubbles. Sustained throughput is 1 char/cycle.
- Reset values while reset=0: state IDLE, hist all 8'h24, off_q/rem_q/lit_q 0, out_valid 0, char_out 0, finish 0, code_ready 0 (forced low during reset), encode 0.
- Reset asserted mid-COPY/LIT aborts the codeword. No further chars are emitted. After release the decoder is in IDLE with fresh history.
- A simultaneous push and read in the same cycle reads the pre-push hist.

## Structure
- Shared package `lz77_pkg` holds:
  - END_SGN, SEARCH_LEN, LOOK_LEN, WCHAR.
  - Offset/length widths (4/3).
  - Decoder state enum {IDLE, COPY, LIT, DONE}.
  - This package is also used by the encoder.
- One sub-module is natural: `lz77_hist_buf`. It is a SEARCH_LEN×WCHAR shift register with push enable, push data, clamped indexed read, and async active-low reset to END_SGN.
- The FSM, codeword registers, and output mux live in lz77_decoder.

## Test plan
- Reset: hold reset=0 for 3 cycles -> out_valid=0, char_out=0, finish=0, code_ready=0. After release: code_ready=1 and hist reads 8'h24 at every offset.
- Literal only: (0,0,'a') -> exactly one cycle out_valid=1 with char_out='a', one cycle after accept, then IDLE.
- Overlapping copy: (0,0,'a') then (0,3,'b') -> char stream a,a,a,a,b.
- Initial history: first codeword (8,2,'c') -> `$`,`$`,'c'.
- Back-to-back: three codewords with code_valid held high:
  - (0,0,'x'), (0,1,'y'), (1,2,'z') -> x,x,y,x,y,z on six consecutive cycles with no gaps.
  - code_ready high only in LIT/IDLE cycles.
- Termination and abort:
  - (0,0,'$') -> '$' emitted, then finish=1 permanently and code_ready=0; a further codeword produces no output.
  - Separately, asserting reset during the second char of (0,5,'q') -> output stops immediately and the decoder restarts clean.
